// File: rtl/seg_scan.sv
// Two-digit multiplexed 7-segment driver for a 0..15 counter value.
// val is resynchronised and debounced into cur; the scan FSM alternates ones and tens with blank gaps.
//
// state | meaning
// ONES  | ones digit lit for SCAN_DIV cycles
// GAP0  | all digits dark for one cycle before tens
// TENS  | tens digit lit (or blanked if a leading zero) for SCAN_DIV cycles
// GAP1  | all digits dark for one cycle before ones
module seg_scan #(
  parameter int SCAN_DIV = 500,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       upd
);

  typedef enum logic [1:0] {ONES, GAP0, TENS, GAP1} state_t;

  localparam logic [9:0] DIV_LAST = 10'(SCAN_DIV - 1);

  state_t     state, state_nxt;
  logic [9:0] div_cnt, div_nxt;
  logic [3:0] s1, s2, s3, cur;
  logic       tens;
  logic [3:0] ones;
  logic [6:0] seg_nxt;
  logic [1:0] an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // s1 is the metastability stage; cur only follows s2 once s2 and s3 agree, rejecting 1-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      cur <= '0;
      upd <= 1'b0;
    end else begin
      s1 <= val;
      s2 <= s1;
      s3 <= s2;
      if (s2 == s3 && s2 != cur) begin
        cur <= s2;
        upd <= 1'b1;
      end else begin
        upd <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ONES;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    case (state)
      ONES: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = GAP0;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 10'd1;
        end
      end
      GAP0: begin
        state_nxt = TENS;
        div_nxt   = '0;
      end
      TENS: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = GAP1;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 10'd1;
        end
      end
      default: begin
        state_nxt = ONES;
        div_nxt   = '0;
      end
    endcase
  end

  assign tens = (cur >= 4'd10);
  assign ones = cur - (tens ? 4'd10 : 4'd0);

  always_comb begin
    an_nxt  = 2'b11;
    seg_nxt = 7'b1111111;
    case (state)
      ONES: begin
        an_nxt  = 2'b10;
        seg_nxt = decode(ones);
      end
      TENS: begin
        if (!(LZ_BLANK && !tens)) begin
          an_nxt  = 2'b01;
          seg_nxt = decode({3'b000, tens});
        end
      end
      default: begin
        an_nxt  = 2'b11;
        seg_nxt = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 2'b11;
      seg <= 7'b1111111;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a cycle model pushes expected outputs of both blanking variants each clk;
// the scenario tasks pop and compare them, plus directed timing and count checks.
module tb_seg_scan;

  localparam int D   = 4;
  localparam int PER = 2 * D + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] val = 4'd0;
  logic [6:0] seg, seg_z;
  logic [1:0] an, an_z;
  logic       upd, upd_z;

  int total = 0;
  int bad   = 0;

  logic [19:0] sb[$];
  logic [19:0] exp_v;
  logic        sb_ok;

  logic [3:0] m_s1, m_s2, m_s3, m_cur;
  int         m_pos;

  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(D), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .val(val), .seg(seg), .an(an), .upd(upd)
  );

  seg_scan #(.SCAN_DIV(D), .LZ_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .val(val), .seg(seg_z), .an(an_z), .upd(upd_z)
  );

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // pos 0..D-1 ones, D gap, D+1..2D tens, 2D+1 gap; result {an,seg,upd} blanking then {an,seg,upd} no blanking
  function automatic logic [19:0] expect_out(input int pos, input logic [3:0] c, input logic u);
    logic [3:0] t, o;
    logic [1:0] a1, a0;
    logic [6:0] g1, g0;
    t  = (c >= 4'd10) ? 4'd1 : 4'd0;
    o  = (c >= 4'd10) ? c - 4'd10 : c;
    a1 = 2'b11; g1 = 7'b1111111;
    a0 = 2'b11; g0 = 7'b1111111;
    if (pos < D) begin
      a1 = 2'b10; g1 = dec(o);
      a0 = 2'b10; g0 = dec(o);
    end else if (pos > D && pos <= 2 * D) begin
      a0 = 2'b01; g0 = dec(t);
      if (t != 4'd0) begin
        a1 = 2'b01; g1 = dec(t);
      end
    end
    return {a1, g1, u, a0, g0, u};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1  <= '0;
      m_s2  <= '0;
      m_s3  <= '0;
      m_cur <= '0;
      m_pos <= 0;
      sb.delete();
    end else begin
      sb.push_back(expect_out(m_pos, m_cur, (m_s2 == m_s3) && (m_s2 != m_cur)));
      m_s1 <= val;
      m_s2 <= m_s1;
      m_s3 <= m_s2;
      if (m_s2 == m_s3 && m_s2 != m_cur) m_cur <= m_s2;
      m_pos <= (m_pos == PER - 1) ? 0 : m_pos + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    sb_ok = (sb.size() != 0);
    exp_v = sb_ok ? sb.pop_front() : 20'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    val = 4'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({an, seg, upd} !== {2'b11, 7'b1111111, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: got an=%b seg=%b upd=%b want 11 1111111 0", an, seg, upd);
    end
    rst = 1'b1;
    for (int k = 0; k < 2 * PER; k++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_reset k=%0d: got %b want %b", k, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
      total++;
      if (an !== (((k % PER) < D) ? 2'b10 : 2'b11)) begin
        bad++;
        $display("FAIL scan_an k=%0d: got %b", k, an);
      end
      if (k == 0) begin
        total++;
        if (seg !== 7'b0000001) begin
          bad++;
          $display("FAIL first_digit: got seg=%b want 0000001", seg);
        end
      end
    end
  endtask

  task automatic test_update();
    int ones_seen, tens_seen;
    ones_seen = 0;
    tens_seen = 0;
    val = 4'd13;
    for (int i = 1; i <= PER + 6; i++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_update i=%0d: got %b want %b", i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
      total++;
      if (upd !== (i == 4)) begin
        bad++;
        $display("FAIL upd_timing edge=%0d: got upd=%b want %b", i, upd, (i == 4));
      end
    end
    for (int i = 0; i < PER; i++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_digits13 i=%0d: got %b want %b", i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
      if (an == 2'b10) begin
        ones_seen++;
        total++;
        if (seg !== 7'b0000110) begin
          bad++;
          $display("FAIL ones13: got seg=%b want 0000110", seg);
        end
      end
      if (an == 2'b01) begin
        tens_seen++;
        total++;
        if (seg !== 7'b1001111) begin
          bad++;
          $display("FAIL tens13: got seg=%b want 1001111", seg);
        end
      end
    end
    total++;
    if (ones_seen != D || tens_seen != D) begin
      bad++;
      $display("FAIL phase_len13: got ones=%0d tens=%0d want %0d each", ones_seen, tens_seen, D);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    val = 4'd7;
    step();
    total++;
    if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
      bad++;
      $display("FAIL sb_glitch0: got %b want %b", {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
    end
    if (upd) pulses++;
    val = 4'd13;
    for (int i = 0; i < PER; i++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_glitch i=%0d: got %b want %b", i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
      if (upd) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL glitch_upd: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_no_blank();
    int tens_seen;
    tens_seen = 0;
    val = 4'd5;
    for (int i = 0; i < 2 * PER + 6; i++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_noblank i=%0d: got %b want %b", i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
      if (i >= 6 && an_z == 2'b01) begin
        tens_seen++;
        total++;
        if (seg_z !== 7'b0000001) begin
          bad++;
          $display("FAIL tens_zero_shown: got seg=%b want 0000001", seg_z);
        end
      end
    end
    total++;
    if (tens_seen != 2 * D) begin
      bad++;
      $display("FAIL tens_zero_len: got %0d want %0d", tens_seen, 2 * D);
    end
  endtask

  task automatic test_rst_mid();
    bit found;
    int pulses;
    found  = 1'b0;
    pulses = 0;
    val = 4'd15;
    for (int i = 0; i < 3 * PER && !found; i++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_pre_rst i=%0d: got %b want %b", i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
      if (i >= 6 && an == 2'b01) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reach_tens15: tens phase not seen within %0d cycles", 3 * PER);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({an, seg, upd} !== {2'b11, 7'b1111111, 1'b0}) begin
      bad++;
      $display("FAIL rst_async: got an=%b seg=%b upd=%b want 11 1111111 0", an, seg, upd);
    end
    repeat (2) @(negedge clk);
    val = 4'd0;
    rst = 1'b1;
    for (int i = 0; i < PER; i++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_post_rst i=%0d: got %b want %b", i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
      if (upd) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL rst_no_upd: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_sweep();
    int pulses;
    pulses = 0;
    val = 4'd15;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
        bad++;
        $display("FAIL sb_sweep_pre i=%0d: got %b want %b", i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
      end
    end
    for (int v = 0; v < 16; v++) begin
      val = 4'(v);
      for (int i = 0; i < 3 * PER; i++) begin
        step();
        total++;
        if (!sb_ok || {an, seg, upd, an_z, seg_z, upd_z} !== exp_v) begin
          bad++;
          $display("FAIL sb_sweep v=%0d i=%0d: got %b want %b", v, i, {an, seg, upd, an_z, seg_z, upd_z}, exp_v);
        end
        if (upd) pulses++;
      end
    end
    total++;
    if (pulses != 16) begin
      bad++;
      $display("FAIL sweep_upd: got %0d pulses want 16", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_glitch();
    test_no_blank();
    test_rst_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
